// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D cache requesters, main memory and mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_rd;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req_rd;
    logic              d_req_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              i_done;
    logic              d_done;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready_to_read;
    logic              mem_finished_writing;
    logic              busy;
    logic              owner;

    modport slave (
        input  i_req_rd, i_addr, d_req_rd, d_req_wr, d_addr, d_wdata,
               mem_ready_to_read, mem_finished_writing,
        output i_done, d_done, mem_read_en, mem_write_en, mem_addr, mem_wdata,
               busy, owner
    );

    modport master (
        output i_req_rd, i_addr, d_req_rd, d_req_wr, d_addr, d_wdata,
               mem_ready_to_read, mem_finished_writing,
        input  i_done, d_done, mem_read_en, mem_write_en, mem_addr, mem_wdata,
               busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache refill / D-cache refill+write-through) main-memory arbiter.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the D side wins ties.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_I_RD    = 3'd1,
        ST_D_RD    = 3'd2,
        ST_D_WR    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_mem_read_en;
    logic              r_mem_write_en;
    logic              r_i_done;
    logic              r_d_done;
    logic              r_busy;
    logic              r_owner;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
`ifdef MEM_ARB_RR_EN
    logic              r_last_owner;
`endif

    logic w_i_req;
    logic w_d_req;
    logic w_grant_d;
    logic w_complete;

    // Winner selection in IDLE; only a tie consults the policy.
    always_comb begin
        w_i_req = bus.i_req_rd;
        w_d_req = bus.d_req_rd | bus.d_req_wr;
        if (w_i_req && w_d_req) begin
`ifdef MEM_ARB_RR_EN
            w_grant_d = ~r_last_owner;
`else
            w_grant_d = 1'b1;
`endif
        end else begin
            w_grant_d = w_d_req;
        end
    end

    // Completion qualified by the active transaction type only.
    always_comb begin
        case (r_state)
            ST_I_RD, ST_D_RD: w_complete = bus.mem_ready_to_read;
            ST_D_WR:          w_complete = bus.mem_finished_writing;
            default:          w_complete = 1'b0;
        endcase
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_i_done       <= 1'b0;
            r_d_done       <= 1'b0;
            r_busy         <= 1'b0;
            r_owner        <= 1'b0;
            r_mem_addr     <= {ADDR_W{1'b0}};
            r_mem_wdata    <= {DATA_W{1'b0}};
`ifdef MEM_ARB_RR_EN
            r_last_owner   <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_i_req || w_d_req) begin
                        r_busy  <= 1'b1;
                        r_owner <= w_grant_d;
`ifdef MEM_ARB_RR_EN
                        r_last_owner <= w_grant_d;
`endif
                        if (w_grant_d) begin
                            r_mem_addr <= bus.d_addr;
                            // A simultaneous data read waits behind the write.
                            if (bus.d_req_wr) begin
                                r_state        <= ST_D_WR;
                                r_mem_write_en <= 1'b1;
                                r_mem_wdata    <= bus.d_wdata;
                            end else begin
                                r_state       <= ST_D_RD;
                                r_mem_read_en <= 1'b1;
                            end
                        end else begin
                            r_mem_addr    <= bus.i_addr;
                            r_state       <= ST_I_RD;
                            r_mem_read_en <= 1'b1;
                        end
                    end
                end
                ST_I_RD, ST_D_RD, ST_D_WR: begin
                    if (w_complete) begin
                        r_state        <= ST_RELEASE;
                        r_mem_read_en  <= 1'b0;
                        r_mem_write_en <= 1'b0;
                        r_i_done       <= ~r_owner;
                        r_d_done       <= r_owner;
                    end
                end
                ST_RELEASE: begin
                    r_state  <= ST_IDLE;
                    r_i_done <= 1'b0;
                    r_d_done <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_mem_read_en  <= 1'b0;
                    r_mem_write_en <= 1'b0;
                    r_i_done       <= 1'b0;
                    r_d_done       <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read_en  = r_mem_read_en;
    assign bus.mem_write_en = r_mem_write_en;
    assign bus.i_done       = r_i_done;
    assign bus.d_done       = r_d_done;
    assign bus.busy         = r_busy;
    assign bus.owner        = r_owner;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b1;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one outstanding transaction, described by who/what/where.
    bit          m_in_txn = 1'b0;
    bit          m_rel    = 1'b0;
    bit [1:0]    m_kind   = 2'd0;   // 0 = I read, 1 = D read, 2 = D write
    bit          m_owner  = 1'b0;
    logic [31:0] m_addr   = 32'd0;
    logic [31:0] m_wdata  = 32'd0;
    bit          grants[$];
    bit          m_ir, m_dr, m_pd;

    function automatic bit tie_goes_to_d();
`ifdef MEM_ARB_RR_EN
        if (grants.size() == 0) return 1'b0;
        return !grants[grants.size()-1];
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_in_txn = 1'b0; m_rel = 1'b0; m_kind = 2'd0; m_owner = 1'b0;
            m_addr = 32'd0; m_wdata = 32'd0;
            grants.delete();
        end else if (!m_in_txn) begin
            m_ir = bus.i_req_rd;
            m_dr = bus.d_req_rd | bus.d_req_wr;
            if (m_ir || m_dr) begin
                m_pd = (m_ir && m_dr) ? tie_goes_to_d() : m_dr;
                grants.push_back(m_pd);
                m_in_txn = 1'b1;
                m_owner  = m_pd;
                if (!m_pd) begin
                    m_kind = 2'd0; m_addr = bus.i_addr;
                end else if (bus.d_req_wr) begin
                    m_kind = 2'd2; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
                end else begin
                    m_kind = 2'd1; m_addr = bus.d_addr;
                end
            end
        end else if (!m_rel) begin
            if (m_kind == 2'd2) m_rel = bus.mem_finished_writing;
            else                m_rel = bus.mem_ready_to_read;
        end else begin
            m_in_txn = 1'b0;
            m_rel    = 1'b0;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        check("read_en",  bus.mem_read_en,  m_in_txn && !m_rel && m_kind != 2'd2);
        check("write_en", bus.mem_write_en, m_in_txn && !m_rel && m_kind == 2'd2);
        check("i_done",   bus.i_done,       m_rel && !m_owner);
        check("d_done",   bus.d_done,       m_rel && m_owner);
        check("busy",     bus.busy,         m_in_txn);
        check("owner",    bus.owner,        m_owner);
        check("mem_addr", bus.mem_addr,     m_addr);
        check("mem_wdata", bus.mem_wdata,   m_wdata);
    end

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    int cnt_rd, cnt_wr, cnt_id, cnt_dd, ng, r;
    logic [3:0] seq;

    initial begin
        bus.i_req_rd = 1'b0; bus.i_addr = 32'd0;
        bus.d_req_rd = 1'b0; bus.d_req_wr = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        bus.mem_ready_to_read = 1'b0; bus.mem_finished_writing = 1'b0;
        #1 reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_owner", bus.owner, 1'b0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_strobes", {bus.mem_read_en, bus.mem_write_en}, 2'b00);
        #2 reset_n = 1'b1;

        // Lone I refill, memory ready on the third strobe cycle.
        @(negedge clk); bus.i_req_rd = 1'b1; bus.i_addr = 32'h100;
        cnt_rd = 0; cnt_id = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) check("r32_addr", bus.mem_addr, 32'h100);
            if (c == 4) check("r32_idle", bus.busy, 1'b0);
            if (bus.mem_read_en) cnt_rd++;
            if (bus.i_done) begin cnt_id++; bus.i_req_rd = 1'b0; end
            bus.mem_ready_to_read = (c == 2);
        end
        check("r32_strobe_cycles", cnt_rd, 3);
        check("r32_done_pulses", cnt_id, 1);

        // Data write and read together: write wins; read-ready is ignored during the write.
        bus.d_req_wr = 1'b1; bus.d_req_rd = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF;
        cnt_dd = 0; cnt_rd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("r33_wr_en", {bus.mem_write_en, bus.mem_read_en}, 2'b10);
                check("r33_wdata", bus.mem_wdata, 32'hDEADBEEF);
                check("r33_addr", bus.mem_addr, 32'h200);
            end
            if (c == 1) check("r33_ignore_rdy", bus.mem_write_en, 1'b1);
            if (bus.mem_read_en) cnt_rd++;
            if (bus.d_done) begin cnt_dd++; bus.d_req_wr = 1'b0; bus.d_req_rd = 1'b0; end
            bus.mem_ready_to_read = (c == 0);
            bus.mem_finished_writing = (c == 1);
        end
        check("r33_done_pulses", cnt_dd, 1);
        check("r33_no_read", cnt_rd, 0);

        // Completion inputs in IDLE and of the wrong type are ignored.
        bus.mem_ready_to_read = 1'b1;
        @(negedge clk); @(negedge clk);
        check("r36_idle_busy", bus.busy, 1'b0);
        check("r36_idle_done", {bus.i_done, bus.d_done}, 2'b00);
        bus.mem_ready_to_read = 1'b0; bus.mem_finished_writing = 1'b1;
        bus.i_req_rd = 1'b1; bus.i_addr = 32'h180;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("r36_hold_i_rd", {bus.mem_read_en, bus.i_done}, 2'b10);
        bus.mem_finished_writing = 1'b0; bus.mem_ready_to_read = 1'b1;
        @(negedge clk);
        check("r36_release", bus.i_done, 1'b1);
        bus.i_req_rd = 1'b0; bus.mem_ready_to_read = 1'b0;
        @(negedge clk);

        // Tie with both sides held: grant order depends on the policy.
        pulse_reset();
        bus.i_req_rd = 1'b1; bus.i_addr = 32'h111;
        bus.d_req_rd = 1'b1; bus.d_addr = 32'h222; bus.mem_ready_to_read = 1'b1;
        ng = 0; seq = 4'b0000;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (bus.i_done || bus.d_done) begin seq[ng] = bus.d_done; ng++; end
        end
        bus.i_req_rd = 1'b0; bus.d_req_rd = 1'b0; bus.mem_ready_to_read = 1'b0;
        check("r34_count", ng, 4);
`ifdef MEM_ARB_RR_EN
        check("r34_grants", seq, 4'b1010);
`else
        check("r34_grants", seq, 4'b1111);
`endif
        @(negedge clk); @(negedge clk);

        // Reset during a data read abandons it without a done pulse.
        bus.d_req_rd = 1'b1; bus.d_addr = 32'h400;
        @(negedge clk); @(negedge clk);
        check("r35_in_d_rd", {bus.mem_read_en, bus.owner}, 2'b11);
        #2 reset_n = 1'b0; #1;
        check("r35_strobe_off", {bus.mem_read_en, bus.mem_write_en}, 2'b00);
        check("r35_busy_off", bus.busy, 1'b0);
        bus.d_req_rd = 1'b0;
        @(negedge clk); #2 reset_n = 1'b1;
        cnt_dd = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.d_done) cnt_dd++;
        end
        check("r35_no_d_done", cnt_dd, 0);
        bus.i_req_rd = 1'b1; bus.i_addr = 32'h300; bus.mem_ready_to_read = 1'b1;
        cnt_id = 0;
        for (int c = 0; c < 10 && cnt_id == 0; c++) begin
            @(negedge clk);
            if (bus.i_done) begin cnt_id++; bus.i_req_rd = 1'b0; end
        end
        check("r35_served_after", cnt_id, 1);
        check("r35_addr_after", bus.mem_addr, 32'h300);
        bus.mem_ready_to_read = 1'b0;
        @(negedge clk);

        // Random traffic, including dropped requests and occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (m_rel && !m_owner) bus.i_req_rd = 1'b0;
            else if (!bus.i_req_rd) begin
                if ($urandom_range(3) == 0) begin bus.i_req_rd = 1'b1; bus.i_addr = $urandom; end
            end else if ($urandom_range(63) == 0) bus.i_req_rd = 1'b0;
            if (m_rel && m_owner) begin
                bus.d_req_rd = 1'b0; bus.d_req_wr = 1'b0;
            end else if (!(bus.d_req_rd || bus.d_req_wr)) begin
                if ($urandom_range(3) == 0) begin
                    r = $urandom_range(2);
                    bus.d_req_rd = (r != 1); bus.d_req_wr = (r != 0);
                    bus.d_addr = $urandom; bus.d_wdata = $urandom;
                end
            end else if ($urandom_range(63) == 0) begin
                bus.d_req_rd = 1'b0; bus.d_req_wr = 1'b0;
            end
            bus.mem_ready_to_read    = ($urandom_range(2) == 0);
            bus.mem_finished_writing = ($urandom_range(2) == 0);
            if ($urandom_range(499) == 0) pulse_reset();
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
